// File: rtl/lab3_q3.sv
// ---------------------------------------------------------------------------
// lab3_q3 : hazard-free four-input logic function unit
//
// Evaluates f = a&~b | b&c on asynchronous inputs a, b, c, d (d does not
// affect f). The combinational output carries the a&c consensus term so that
// a single-input change never produces a static glitch. A clocked path
// synchronizes the inputs, registers f, flags multi-bit input changes and
// keeps two saturating event counters for debug.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   a, b, c, d  in   asynchronous function inputs ({a,b,c,d}, a = MSB)
//   y           out  combinational f from raw inputs, hazard-free cover
//   y_q         out  registered f of the synchronized input vector
//   multi_chg   out  one-cycle pulse: synchronized vector changed in >=2 bits
//   toggle_cnt  out  number of y_q transitions since reset (saturating)
//   mchg_cnt    out  number of multi_chg pulses since reset (saturating)
// ---------------------------------------------------------------------------
module lab3_q3 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             y,
    output logic             y_q,
    output logic             multi_chg,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] mchg_cnt
);

    // f without the redundant term; the registered path cannot glitch.
    function automatic logic f_eval(input logic fa, input logic fb, input logic fc);
        return (fa & ~fb) | (fb & fc);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set, i.e. popcount(x) >= 2 without an adder tree.
    function automatic logic multi_bit(input logic [3:0] x);
        return (x & (x - 4'd1)) != 4'd0;
    endfunction

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Combinational cover: a&c is logically redundant but bridges the
    // a=1,c=1 transition on b. Kept as its own net so synthesis keeps it.
    (* keep = "true" *) logic term_ab;
    (* keep = "true" *) logic term_bc;
    (* keep = "true" *) logic term_ac;

    assign term_ab = a & ~b;
    assign term_bc = b & c;
    assign term_ac = a & c;
    assign y       = term_ab | term_bc | term_ac;

    logic [3:0] s1_p0;      // first synchronizer rank (may be metastable)
    logic [3:0] s2_p1;      // second synchronizer rank: the vector v
    logic [3:0] v_prev_p2;  // v from the previous cycle

    logic f_next;
    logic mchg_next;

    assign f_next    = f_eval(s2_p1[3], s2_p1[2], s2_p1[1]);
    assign mchg_next = multi_bit(s2_p1 ^ v_prev_p2);

    // ---- stage 0/1: two-flop synchronizer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p0 <= 4'b0000;
            s2_p1 <= 4'b0000;
        end else begin
            s1_p0 <= {a, b, c, d};
            s2_p1 <= s1_p0;
        end
    end

    // ---- stage 2: registered function, change detect, counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_prev_p2  <= 4'b0000;
            y_q        <= 1'b0;
            multi_chg  <= 1'b0;
            toggle_cnt <= '0;
            mchg_cnt   <= '0;
        end else begin
            v_prev_p2 <= s2_p1;
            y_q       <= f_next;
            multi_chg <= mchg_next;
            if (f_next != y_q) begin
                toggle_cnt <= sat_inc(toggle_cnt);
            end
            if (mchg_next) begin
                mchg_cnt <= sat_inc(mchg_cnt);
            end
        end
    end

endmodule

// File: tb/tb_lab3_q3.sv
// ---------------------------------------------------------------------------
// tb_lab3_q3 : self-checking bench for lab3_q3
//
// Each applied vector pushes its expected registered outcome to a queue; the
// entry is popped and compared three clock edges later when the DUT output
// for that vector appears. The combinational output is checked right after
// the inputs change.
// ---------------------------------------------------------------------------
module tb_lab3_q3;

    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             a, b, c, d;
    logic             y;
    logic             y_q;
    logic             multi_chg;
    logic [CNT_W-1:0] toggle_cnt;
    logic [CNT_W-1:0] mchg_cnt;

    lab3_q3 #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .y          (y),
        .y_q        (y_q),
        .multi_chg  (multi_chg),
        .toggle_cnt (toggle_cnt),
        .mchg_cnt   (mchg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vec;
        logic       f;
        logic       mchg;
        int         tcnt;
        int         mcnt;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Truth table from the function description, bit index = {a,b,c,d}.
    logic [15:0] truth;
    logic [3:0]  prev_vec;
    logic        prev_f;
    int          m_tcnt;
    int          m_mcnt;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        prev_vec = 4'b0000;
        prev_f   = 1'b0;
        m_tcnt   = 0;
        m_mcnt   = 0;
        exp_q.delete();
    endtask

    // Drive one vector, hold it for 'hold' cycles (>= 4), check everything.
    task automatic apply(input logic [3:0] vec, input int hold);
        exp_t e;
        exp_t got_e;
        @(posedge clk);
        #1;
        {a, b, c, d} = vec;
        e.vec  = vec;
        e.f    = truth[vec];
        e.mchg = ($countones(vec ^ prev_vec) >= 2);
        if (e.f != prev_f && m_tcnt < SAT) m_tcnt++;
        if (e.mchg && m_mcnt < SAT) m_mcnt++;
        e.tcnt = m_tcnt;
        e.mcnt = m_mcnt;
        prev_vec = vec;
        prev_f   = e.f;
        exp_q.push_back(e);
        #1;
        check($sformatf("y[%b]", vec), int'(y), int'(e.f));
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got_e = exp_q.pop_front();
            check($sformatf("y_q[%b]", got_e.vec), int'(y_q), int'(got_e.f));
            check($sformatf("multi_chg[%b]", got_e.vec), int'(multi_chg), int'(got_e.mchg));
            check($sformatf("toggle_cnt[%b]", got_e.vec), int'(toggle_cnt), got_e.tcnt);
            check($sformatf("mchg_cnt[%b]", got_e.vec), int'(mchg_cnt), got_e.mcnt);
        end
        @(posedge clk);
        #1;
        check($sformatf("multi_chg_drop[%b]", vec), int'(multi_chg), 0);
        repeat (hold - 4) @(posedge clk);
    endtask

    logic [3:0] sweep [16];

    initial begin
        truth = 16'hCFC0;
        model_reset();

        // Reset asserted with all inputs high.
        rst = 1'b1;
        {a, b, c, d} = 4'b1111;
        #1;
        check("reset_y_q", int'(y_q), 0);
        check("reset_multi_chg", int'(multi_chg), 0);
        check("reset_toggle_cnt", int'(toggle_cnt), 0);
        check("reset_mchg_cnt", int'(mchg_cnt), 0);
        check("reset_y_comb", int'(y), 1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_y_q", int'(y_q), 0);
        check("reset_hold_toggle", int'(toggle_cnt), 0);
        {a, b, c, d} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Truth sweep in table order.
        sweep = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0100, 4'b0101, 4'b0111,
                  4'b0010, 4'b0011, 4'b1011, 4'b0001, 4'b1001, 4'b1010, 4'b1101, 4'b0110};
        for (int i = 0; i < 16; i++) apply(sweep[i], 4);

        // Hazard path: single-bit steps with a=1, c=1 around the b change.
        apply(4'b1100, 5);
        apply(4'b1110, 5);
        check("hazard_y_hold", int'(y), 1);
        apply(4'b1010, 5);
        check("hazard_y_after", int'(y), 1);

        // Three-bit change.
        apply(4'b1111, 5);
        apply(4'b0100, 5);

        // Saturation: single-bit toggles of f.
        apply(4'b0000, 4);
        for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? 4'b1000 : 4'b0000, 4);
        check("sat_toggle_cnt", int'(toggle_cnt), SAT);

        // Reset mid-run, then a two-bit first vector.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_toggle_cnt", int'(toggle_cnt), 0);
        check("midrst_mchg_cnt", int'(mchg_cnt), 0);
        check("midrst_y_q", int'(y_q), 0);
        model_reset();
        {a, b, c, d} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(4'b1010, 5);
        check("midrst_final_mchg_cnt", int'(mchg_cnt), 1);
        check("midrst_final_toggle_cnt", int'(toggle_cnt), 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
